// File: rtl/accumulator_bank.sv
// Bank of NUM_ACC accumulators sharing one data bus: loads, single-cycle ALU ops,
// a registered bus output and global Z/N/C/V status flags for branch logic.
module accumulator_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_ACC  = 4,
  parameter bit          SATURATE = 1'b0,
  localparam int unsigned SELW    = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] acc_in,
  input  logic [SELW-1:0]  sel,
  input  logic             WE,
  input  logic             load,
  input  logic             op_en,
  input  logic [2:0]       op,
  input  logic             OE,
  output logic [WIDTH-1:0] acc_out,
  output logic             out_valid,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_CLR = 3'b111;

  logic [WIDTH-1:0] acc [NUM_ACC];

  logic             sel_ok;
  logic [WIDTH-1:0] a_val;
  logic             wr;
  logic             update;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] result;
  logic             res_c;
  logic             res_v;
  logic [WIDTH-1:0] next_val;
  logic             next_c;
  logic             next_v;

  // Selected accumulator value; out-of-range selects read as zero and block updates
  always_comb begin
    sel_ok = 1'b0;
    a_val  = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (sel == SELW'(i)) begin
        sel_ok = 1'b1;
        a_val  = acc[i];
      end
    end
  end

  // ALU: C and V always report the unclamped arithmetic event
  always_comb begin
    sum    = {1'b0, a_val} + {1'b0, acc_in};
    diff   = {1'b0, a_val} - {1'b0, acc_in};
    result = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        res_c  = sum[WIDTH];
        res_v  = (a_val[WIDTH-1] == acc_in[WIDTH-1]) && (sum[WIDTH-1] != a_val[WIDTH-1]);
        if (SATURATE && sum[WIDTH]) result = '1;
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        res_c  = diff[WIDTH];
        res_v  = (a_val[WIDTH-1] != acc_in[WIDTH-1]) && (diff[WIDTH-1] != a_val[WIDTH-1]);
        if (SATURATE && diff[WIDTH]) result = '0;
      end
      OP_AND: result = a_val & acc_in;
      OP_OR:  result = a_val | acc_in;
      OP_XOR: result = a_val ^ acc_in;
      OP_SHL: begin
        result = a_val << 1;
        res_c  = a_val[WIDTH-1];
      end
      OP_SHR: begin
        result = a_val >> 1;
        res_c  = a_val[0];
      end
      OP_CLR: result = '0;
      default: result = '0;
    endcase
  end

  // Writes win over ops; flags follow whichever one commits
  always_comb begin
    wr       = WE | load;
    update   = (wr | op_en) & sel_ok;
    next_val = wr ? acc_in : result;
    next_c   = wr ? 1'b0 : res_c;
    next_v   = wr ? 1'b0 : res_v;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
      acc_out   <= '0;
      out_valid <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      if (update) begin
        for (int i = 0; i < NUM_ACC; i++) begin
          if (sel == SELW'(i)) acc[i] <= next_val;
        end
        flag_z <= (next_val == '0);
        flag_n <= next_val[WIDTH-1];
        flag_c <= next_c;
        flag_v <= next_v;
      end
      // Read-before-write: a_val is the pre-edge contents
      if (OE) acc_out <= a_val;
      out_valid <= OE;
    end
  end

endmodule
